// File: rtl/ex_mem_skid_stage.sv
// EX->MEM two-entry skid buffer: narrows the ALU result, sanitises flags and drives a forwarding tap.
// Optional STAGE_PERF_CNT_EN adds stall and flush counters.
module ex_mem_skid_stage #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned RES_W = 128,
  parameter int unsigned RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] in_result,
  input  logic             in_zero,
  input  logic             in_overflow,
  input  logic [3:0]       in_alu_ctrl,
  input  logic [RD_W-1:0]  in_rd,
  input  logic [XLEN-1:0]  in_store_data,
  input  logic             in_mem_read,
  input  logic             in_mem_write,
  input  logic             in_reg_write,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_alu_result,
  output logic [XLEN-1:0]  out_mul_hi,
  output logic             out_zero,
  output logic             out_overflow,
  output logic [RD_W-1:0]  out_rd,
  output logic [XLEN-1:0]  out_store_data,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_reg_write,
  output logic             fwd_valid,
  output logic [RD_W-1:0]  fwd_rd,
  output logic [XLEN-1:0]  fwd_data
`ifdef STAGE_PERF_CNT_EN
  ,
  output logic [31:0]      perf_stall_cycles,
  output logic [31:0]      perf_flush_count
`endif
);

  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluMul = 4'b0011;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] mul_hi;
    logic            zero;
    logic            overflow;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] store_data;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
  } entry_t;

  // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b10,
    StFull  = 2'b11
  } state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d, cap;
  logic   main_valid, skid_valid, accept, drain;

  assign main_valid = state_q[1];
  assign skid_valid = state_q[0];
  assign in_ready   = !skid_valid;
  assign accept     = in_valid && in_ready;
  assign drain      = main_valid && out_ready;

  always_comb begin
    cap            = '0;
    cap.alu_result = in_result[XLEN-1:0];
    cap.mul_hi     = (in_alu_ctrl == AluMul) ? in_result[RES_W-1:XLEN] : '0;
    cap.zero       = in_zero;
    // Overflow is stale on ops that do not compute it.
    cap.overflow   = ((in_alu_ctrl == AluAdd) || (in_alu_ctrl == AluSub)) && in_overflow;
    cap.rd         = in_rd;
    cap.store_data = in_store_data;
    cap.mem_read   = in_mem_read;
    cap.mem_write  = in_mem_write;
    cap.reg_write  = in_reg_write && (in_rd != '0);
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d  = cap;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && drain) begin
          main_d = cap;
        end else if (accept) begin
          skid_d  = cap;
          state_d = StFull;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (drain) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush) state_d = StEmpty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_valid      = main_valid;
  assign out_alu_result = main_q.alu_result;
  assign out_mul_hi     = main_q.mul_hi;
  assign out_zero       = main_q.zero;
  assign out_overflow   = main_q.overflow;
  assign out_rd         = main_q.rd;
  assign out_store_data = main_q.store_data;
  assign out_mem_read   = main_q.mem_read;
  assign out_mem_write  = main_q.mem_write;
  assign out_reg_write  = main_q.reg_write;

  // Load data is not available yet, so loads are never forwarded from here.
  assign fwd_valid = main_valid && main_q.reg_write && !main_q.mem_read;
  assign fwd_rd    = main_q.rd;
  assign fwd_data  = main_q.alu_result;

`ifdef STAGE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (main_valid && !out_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush && (main_valid || skid_valid)) perf_flush_count <= perf_flush_count + 32'd1;
    end
  end
`endif

endmodule
